// File: rtl/image_rx_pkg.sv
// Shared types and constants for the UART image-frame receiver.
package image_rx_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StPayload,
        StCheck
    } rx_state_e;

    localparam logic [2:0] ErrNone     = 3'd0;
    localparam logic [2:0] ErrBadChar  = 3'd1;
    localparam logic [2:0] ErrChecksum = 3'd2;
    localparam logic [2:0] ErrTimeout  = 3'd3;
    localparam logic [2:0] ErrBreak    = 3'd4;
    localparam logic [2:0] ErrOverrun  = 3'd5;

    localparam logic [7:0] AsciiZero = 8'h30;
    localparam logic [7:0] AsciiOne  = 8'h31;
    localparam logic [7:0] AsciiCr   = 8'h0D;
    localparam logic [7:0] AsciiLf   = 8'h0A;

    function automatic logic is_ascii_pixel(input logic [7:0] b);
        return (b == AsciiZero) || (b == AsciiOne);
    endfunction

    function automatic logic is_ascii_skip(input logic [7:0] b);
        return (b == AsciiCr) || (b == AsciiLf);
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1-style UART receiver: mid-bit sampling, one-cycle valid pulse, break flag on an
// all-zero character whose stop bit is also low.
module uart_rx #(
    parameter int unsigned BIT_RATE     = 9600,
    parameter int unsigned CLK_HZ       = 100000000,
    parameter int unsigned PAYLOAD_BITS = 8
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    uart_rxd,
    input  logic                    uart_rx_en,
    output logic                    uart_rx_break,
    output logic                    uart_rx_valid,
    output logic [PAYLOAD_BITS-1:0] uart_rx_data
);

    localparam int unsigned CycPerBit = CLK_HZ / BIT_RATE;
    localparam int unsigned CntW      = $clog2(CycPerBit);
    localparam int unsigned BitW      = $clog2(PAYLOAD_BITS);

    localparam logic [CntW-1:0] CntLast = CntW'(CycPerBit - 1);
    localparam logic [CntW-1:0] CntHalf = CntW'(CycPerBit / 2 - 1);
    localparam logic [BitW-1:0] BitLast = BitW'(PAYLOAD_BITS - 1);

    typedef enum logic [2:0] {
        RxIdle,
        RxStart,
        RxData,
        RxStop,
        RxWaitHigh
    } uart_state_e;

    uart_state_e             state_q;
    logic                    rxd_meta_q;
    logic                    rxd_q;
    logic [CntW-1:0]         cnt_q;
    logic [BitW-1:0]         bit_q;
    logic [PAYLOAD_BITS-1:0] data_q;

    assign uart_rx_data = data_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= RxIdle;
            rxd_meta_q    <= 1'b1;
            rxd_q         <= 1'b1;
            cnt_q         <= '0;
            bit_q         <= '0;
            data_q        <= '0;
            uart_rx_valid <= 1'b0;
            uart_rx_break <= 1'b0;
        end else begin
            rxd_meta_q    <= uart_rxd;
            rxd_q         <= rxd_meta_q;
            uart_rx_valid <= 1'b0;
            uart_rx_break <= 1'b0;
            case (state_q)
                RxIdle: begin
                    if (uart_rx_en && !rxd_q) begin
                        cnt_q   <= '0;
                        state_q <= RxStart;
                    end
                end
                RxStart: begin
                    // Re-check at mid start bit so glitches do not start a character.
                    if (cnt_q == CntHalf) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        state_q <= rxd_q ? RxIdle : RxData;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RxData: begin
                    if (cnt_q == CntLast) begin
                        cnt_q  <= '0;
                        data_q <= {rxd_q, data_q[PAYLOAD_BITS-1:1]};
                        if (bit_q == BitLast) begin
                            state_q <= RxStop;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RxStop: begin
                    if (cnt_q == CntLast) begin
                        cnt_q <= '0;
                        if (rxd_q) begin
                            uart_rx_valid <= 1'b1;
                            state_q       <= RxIdle;
                        end else begin
                            // Framing error; only an all-zero character counts as break.
                            uart_rx_break <= (data_q == '0);
                            state_q       <= RxWaitHigh;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RxWaitHigh: begin
                    if (rxd_q) begin
                        state_q <= RxIdle;
                    end
                end
                default: state_q <= RxIdle;
            endcase
        end
    end

endmodule

// File: rtl/image_frame_rx.sv
// Framed UART image receiver: SOF sync, XOR checksum, inter-byte timeout, ASCII or raw
// pixels, and a valid/ready output with overrun reporting.
module image_frame_rx
    import image_rx_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 100000000,
    parameter int unsigned BIT_RATE    = 9600,
    parameter int unsigned PIXELS      = 121,
    parameter int unsigned PIX_W       = 1,
    parameter int unsigned MODE        = 0,
    parameter logic [7:0]  SOF         = 8'h53,
    parameter int unsigned TIMEOUT_CYC = CLK_HZ / BIT_RATE * 40
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      uart_rxd,
    output logic [PIXELS*PIX_W-1:0]   frame_data,
    output logic                      frame_valid,
    input  logic                      frame_ready,
    output logic                      frame_err,
    output logic [2:0]                err_code,
    output logic                      busy
);

    localparam int unsigned FrameW = PIXELS * PIX_W;
    localparam int unsigned CntW   = $clog2(PIXELS + 1);
    localparam int unsigned GapW   = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CntW-1:0] CntLast = CntW'(PIXELS - 1);
    localparam logic [GapW-1:0] GapLast = GapW'(TIMEOUT_CYC - 1);

    if ((MODE == 0 && PIX_W != 1) || PIX_W > 8 || PIX_W < 1 || MODE > 1) begin : g_bad_cfg
        $error("image_frame_rx: unsupported MODE/PIX_W combination");
    end

    logic       uart_resetn;
    logic       rx_valid;
    logic       rx_break;
    logic [7:0] rx_data;

    assign uart_resetn = !rst && enable;

    uart_rx #(
        .BIT_RATE    (BIT_RATE),
        .CLK_HZ      (CLK_HZ),
        .PAYLOAD_BITS(8)
    ) u_uart_rx (
        .clk          (clk),
        .resetn       (uart_resetn),
        .uart_rxd     (uart_rxd),
        .uart_rx_en   (1'b1),
        .uart_rx_break(rx_break),
        .uart_rx_valid(rx_valid),
        .uart_rx_data (rx_data)
    );

    rx_state_e         state_q;
    logic [CntW-1:0]   cnt_q;
    logic [GapW-1:0]   gap_q;
    logic [7:0]        csum_q;
    logic [FrameW-1:0] shadow_q;
    logic [FrameW-1:0] frame_data_q;
    logic              frame_valid_q;
    logic              frame_err_q;
    logic [2:0]        err_code_q;

    logic [PIX_W-1:0]  pix;
    logic              byte_skip;
    logic              byte_bad;

    always_comb begin
        pix       = rx_data[7 -: PIX_W];
        byte_skip = 1'b0;
        byte_bad  = 1'b0;
        if (MODE == 0) begin
            pix       = PIX_W'(rx_data[0]);
            byte_skip = is_ascii_skip(rx_data);
            byte_bad  = !byte_skip && !is_ascii_pixel(rx_data);
        end
    end

    assign frame_data  = frame_data_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign err_code    = err_code_q;
    assign busy        = (state_q != StIdle);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            gap_q         <= '0;
            csum_q        <= '0;
            shadow_q      <= '0;
            frame_data_q  <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            err_code_q    <= ErrNone;
        end else if (!enable) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            gap_q         <= '0;
            csum_q        <= '0;
            shadow_q      <= '0;
            frame_data_q  <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            err_code_q    <= ErrNone;
        end else begin
            frame_err_q <= 1'b0;
            if (frame_valid_q && frame_ready) begin
                frame_valid_q <= 1'b0;
            end
            if (state_q != StIdle) begin
                gap_q <= rx_valid ? '0 : gap_q + 1'b1;
            end

            case (state_q)
                StIdle: begin
                    if (rx_valid && rx_data == SOF) begin
                        cnt_q    <= '0;
                        csum_q   <= '0;
                        shadow_q <= '0;
                        gap_q    <= '0;
                        state_q  <= StPayload;
                    end
                end
                StPayload, StCheck: begin
                    if (rx_break) begin
                        err_code_q  <= ErrBreak;
                        frame_err_q <= 1'b1;
                        state_q     <= StIdle;
                    end else if (!rx_valid && gap_q == GapLast) begin
                        err_code_q  <= ErrTimeout;
                        frame_err_q <= 1'b1;
                        state_q     <= StIdle;
                    end else if (rx_valid && state_q == StPayload) begin
                        if (byte_bad) begin
                            err_code_q  <= ErrBadChar;
                            frame_err_q <= 1'b1;
                            state_q     <= StIdle;
                        end else if (!byte_skip) begin
                            csum_q                       <= csum_q ^ rx_data;
                            shadow_q[cnt_q*PIX_W +: PIX_W] <= pix;
                            if (cnt_q == CntLast) begin
                                state_q <= StCheck;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                    end else if (rx_valid) begin
                        state_q <= StIdle;
                        if (rx_data != csum_q) begin
                            err_code_q  <= ErrChecksum;
                            frame_err_q <= 1'b1;
                        end else if (frame_valid_q && !frame_ready) begin
                            err_code_q  <= ErrOverrun;
                            frame_err_q <= 1'b1;
                        end else begin
                            // Overrides the handshake clear when a commit lands on it.
                            frame_data_q  <= shadow_q;
                            frame_valid_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_image_frame_rx.sv
// Directed bench: an ASCII 4x1 instance and a raw 2x4 instance driven by a bit-level UART model.
module tb_image_frame_rx;

    localparam int unsigned ClkHz = 160;
    localparam int unsigned Baud  = 10;
    localparam int unsigned BitT  = ClkHz / Baud;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, enable;
    logic       rxd0, rxd1, ready0, ready1;
    logic [3:0] data0;
    logic [7:0] data1;
    logic       valid0, valid1, ferr0, ferr1, busy0, busy1;
    logic [2:0] code0, code1;

    image_frame_rx #(
        .CLK_HZ(ClkHz), .BIT_RATE(Baud), .PIXELS(4), .PIX_W(1), .MODE(0),
        .SOF(8'h53), .TIMEOUT_CYC(640)
    ) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .uart_rxd(rxd0),
        .frame_data(data0), .frame_valid(valid0), .frame_ready(ready0),
        .frame_err(ferr0), .err_code(code0), .busy(busy0)
    );

    image_frame_rx #(
        .CLK_HZ(ClkHz), .BIT_RATE(Baud), .PIXELS(2), .PIX_W(4), .MODE(1),
        .SOF(8'h53), .TIMEOUT_CYC(640)
    ) dut1 (
        .clk(clk), .rst(rst), .enable(enable), .uart_rxd(rxd1),
        .frame_data(data1), .frame_valid(valid1), .frame_ready(ready1),
        .frame_err(ferr1), .err_code(code1), .busy(busy1)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int errs0    = 0;
    int lows0    = 0;
    int e0, l0;
    bit found;
    logic [7:0] seq [$];

    always @(negedge clk) begin
        if (ferr0) errs0 <= errs0 + 1;
        if (!valid0) lows0 <= lows0 + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_line(input int ch, input logic v);
        if (ch == 0) rxd0 = v;
        else rxd1 = v;
    endtask

    task automatic send_byte(input int ch, input logic [7:0] b);
        set_line(ch, 1'b0);
        repeat (BitT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            set_line(ch, b[i]);
            repeat (BitT) @(negedge clk);
        end
        set_line(ch, 1'b1);
        repeat (BitT) @(negedge clk);
    endtask

    task automatic send_seq(input int ch);
        foreach (seq[i]) send_byte(ch, seq[i]);
        repeat (4) @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic consume0();
        ready0 = 1'b1;
        @(negedge clk);
        ready0 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; rxd0 = 1'b1; rxd1 = 1'b1; ready0 = 1'b0; ready1 = 1'b0;
        idle(5);
        check("rst_valid0", valid0, 0);
        check("rst_data0", data0, 0);
        check("rst_code0", code0, 0);
        check("rst_busy0", busy0, 0);
        check("rst_ferr0", ferr0, 0);
        check("rst_data1", data1, 0);
        rst = 1'b0;
        idle(40);

        // Good ASCII frame: pixels 1,0,1,1 -> 4'hD, checksum 0x01
        e0 = errs0;
        seq = '{8'h53, 8'h31, 8'h30, 8'h31, 8'h31, 8'h01};
        send_seq(0);
        check("good_data", data0, 4'hD);
        check("good_valid", valid0, 1);
        check("good_noerr", errs0 - e0, 0);
        check("good_busy", busy0, 0);
        consume0();
        check("consume_valid", valid0, 0);

        // Bad checksum
        e0 = errs0;
        seq = '{8'h53, 8'h31, 8'h30, 8'h31, 8'h31, 8'h00};
        send_seq(0);
        check("csum_pulse", errs0 - e0, 1);
        check("csum_code", code0, 2);
        check("csum_valid", valid0, 0);

        // CR/LF skipped mid-payload
        seq = '{8'h53, 8'h31, 8'h0D, 8'h30, 8'h0A, 8'h31, 8'h31, 8'h01};
        send_seq(0);
        check("crlf_data", data0, 4'hD);
        check("crlf_valid", valid0, 1);
        check("crlf_code_held", code0, 2);
        consume0();

        // Bad character
        e0 = errs0;
        seq = '{8'h53, 8'h31, 8'h32};
        send_seq(0);
        check("badch_code", code0, 1);
        check("badch_pulse", errs0 - e0, 1);
        check("badch_busy", busy0, 0);

        // Raw mode, 4-bit pixels
        seq = '{8'h53, 8'hA0, 8'h5F, 8'hFF};
        send_seq(1);
        check("raw_data", data1, 8'h5A);
        check("raw_valid", valid1, 1);
        check("raw_code", code1, 0);
        ready1 = 1'b1; @(negedge clk); ready1 = 1'b0; @(negedge clk);
        check("raw_consume", valid1, 0);
        seq = '{8'h53, 8'h12, 8'h34, 8'h26};
        send_seq(1);
        check("raw2_data", data1, 8'h31);
        check("raw2_valid", valid1, 1);

        // Overrun: second frame dropped while the first is unconsumed
        seq = '{8'h53, 8'h31, 8'h31, 8'h31, 8'h31, 8'h00};
        send_seq(0);
        check("ovr_first", data0, 4'hF);
        e0 = errs0;
        seq = '{8'h53, 8'h30, 8'h30, 8'h30, 8'h31, 8'h01};
        send_seq(0);
        check("ovr_data_kept", data0, 4'hF);
        check("ovr_valid", valid0, 1);
        check("ovr_code", code0, 5);
        check("ovr_pulse", errs0 - e0, 1);

        // Commit coinciding with the consumer handshake
        e0 = errs0;
        l0 = lows0;
        found = 1'b0;
        seq = '{8'h53, 8'h30, 8'h30, 8'h30, 8'h31};
        foreach (seq[i]) send_byte(0, seq[i]);
        fork
            send_byte(0, 8'h01);
            begin
                for (int i = 0; i < 400; i++) begin
                    @(negedge clk);
                    if (dut0.rx_valid) begin
                        found = 1'b1;
                        break;
                    end
                end
                ready0 = 1'b1;
                @(negedge clk);
                ready0 = 1'b0;
            end
        join
        idle(4);
        check("coin_found", found, 1);
        check("coin_data", data0, 4'h8);
        check("coin_valid", valid0, 1);
        check("coin_no_gap", lows0 - l0, 0);
        check("coin_no_err", errs0 - e0, 0);
        consume0();
        check("coin_consume", valid0, 0);

        // Timeout mid-frame, then recovery
        e0 = errs0;
        seq = '{8'h53, 8'h31, 8'h30};
        send_seq(0);
        check("to_busy_before", busy0, 1);
        idle(700);
        check("to_code", code0, 3);
        check("to_busy", busy0, 0);
        check("to_pulse", errs0 - e0, 1);
        seq = '{8'h53, 8'h31, 8'h30, 8'h31, 8'h31, 8'h01};
        send_seq(0);
        check("to_recover_valid", valid0, 1);
        check("to_recover_data", data0, 4'hD);
        consume0();

        // Break mid-frame
        e0 = errs0;
        seq = '{8'h53, 8'h31};
        send_seq(0);
        set_line(0, 1'b0);
        idle(BitT * 12);
        set_line(0, 1'b1);
        idle(BitT * 3);
        check("brk_code", code0, 4);
        check("brk_busy", busy0, 0);
        check("brk_pulse", errs0 - e0, 1);
        check("brk_valid", valid0, 0);

        // Asynchronous reset mid-payload
        seq = '{8'h53, 8'h31, 8'h30, 8'h31, 8'h31, 8'h01};
        send_seq(0);
        seq = '{8'h53, 8'h31};
        send_seq(0);
        check("arst_busy_before", busy0, 1);
        rst = 1'b1;
        #1;
        check("arst_valid", valid0, 0);
        check("arst_data", data0, 0);
        check("arst_code", code0, 0);
        check("arst_busy", busy0, 0);
        idle(3);
        rst = 1'b0;
        idle(40);

        // Soft clear via enable
        seq = '{8'h53, 8'h31, 8'h32};
        send_seq(0);
        seq = '{8'h53, 8'h31, 8'h30, 8'h31, 8'h31, 8'h01};
        send_seq(0);
        check("en_pre_valid", valid0, 1);
        check("en_pre_code", code0, 1);
        enable = 1'b0;
        @(negedge clk);
        check("en_valid", valid0, 0);
        check("en_data", data0, 0);
        check("en_code", code0, 0);
        enable = 1'b1;
        idle(40);
        send_seq(0);
        check("en_recover", data0, 4'hD);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
